uart_rx_core: RTL and testbench

- Receive half of the UART DUT.
- Consumes the serial rx pin driven by the bench, oversamples it 16x from a programmable baud divisor, and deframes start, data, optional parity and stop bits.
- Presents each received byte through a one-entry valid/ready holding register to the register-interface block, which exposes it on rdata.
- Sits between the rx pin and the register file.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 27 ++
 rtl/uart_rx_core.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types, defaults and helpers.
// Used by the rx core and the baud tick generator.
package uart_pkg;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    // Expected parity bit for a data word (zero padding does not change it).
    function automatic logic calc_parity(
        input logic [31:0] data,
        input logic        odd
    );
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one tick every div+1 clocks.
// Shared between the rx and tx cores.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;

    assign tick = (r_cnt == div);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled deframer feeding a
// one-entry valid/ready holding register.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [SW-1:0] MID_S  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] LAST_S = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_B = BW'(DATA_BITS - 1);

    logic                 r_s1;
    logic                 r_s2;
    rx_state_e            r_state;
    logic [SW-1:0]        r_scnt;
    logic [BW-1:0]        r_bcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DIV_W-1:0]     r_div;
    logic                 r_pen;
    logic                 r_podd;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_done;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    logic w_rxs;
    logic w_tick;
    logic w_clear;
    logic w_sample;

    assign w_rxs    = r_s2;
    assign w_clear  = (r_state == IDLE) && !w_rxs;
    assign w_sample = w_tick && (r_scnt == MID_S);

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .div   (r_div),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= rx;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_scnt  <= '0;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_div   <= '0;
            r_pen   <= 1'b0;
            r_podd  <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_tick) begin
                r_scnt <= (r_scnt == LAST_S) ? '0 : r_scnt + 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    // Frame settings are frozen here for the whole frame.
                    if (!w_rxs) begin
                        r_state <= START;
                        r_scnt  <= '0;
                        r_div   <= baud_div;
                        r_pen   <= parity_en;
                        r_podd  <= parity_odd;
                        r_perr  <= 1'b0;
                    end
                end
                START: begin
                    if (w_sample) begin
                        r_state <= w_rxs ? IDLE : DATA;
                        r_bcnt  <= '0;
                    end
                end
                DATA: begin
                    if (w_sample) begin
                        r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                        r_bcnt  <= r_bcnt + 1'b1;
                        if (r_bcnt == LAST_B) begin
                            r_state <= r_pen ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (w_sample) begin
                        r_perr  <= w_rxs != calc_parity(32'(r_shift), r_podd);
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    // Leave at mid-stop so the next start edge is not missed.
                    if (w_sample) begin
                        r_done  <= 1'b1;
                        r_ferr  <= !w_rxs;
                        r_state <= w_rxs ? IDLE : BREAK;
                    end
                end
                BREAK: begin
                    if (w_rxs) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_done) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data    <= r_shift;
                    r_frame_err  <= r_ferr;
                    r_parity_err <= r_perr;
                    r_rx_valid   <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: directed frames in,
// expected bytes queued, a monitor checks each accepted byte.
module tb_uart_rx_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        rx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        frame_err;
    logic        parity_err;
    logic        overrun;
    logic        busy;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   errors = 0;
    int   checks = 0;
    int   ov_cnt = 0;
    int   lat;

    uart_rx_core dut (
        .clk        (clk),
        .rst        (rst),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic fe,
                               input logic pe);
        exp_t e;
        e.d  = d;
        e.fe = fe;
        e.pe = pe;
        q.push_back(e);
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen,
                              input logic pbit, input logic stop,
                              input int bt);
        drive_bit(1'b0, bt);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i], bt);
        end
        if (pen) begin
            drive_bit(pbit, bt);
        end
        drive_bit(stop, bt);
        drive_bit(1'b1, bt);
    endtask

    always @(negedge clk) begin
        if (overrun) begin
            ov_cnt++;
        end
        if (!rst && rx_valid && rx_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %02h expected none",
                         rx_data);
            end else begin
                m_e = q.pop_front();
                chk("rx_data", 32'(rx_data), 32'(m_e.d));
                chk("frame_err", 32'(frame_err), 32'(m_e.fe));
                chk("parity_err", 32'(parity_err), 32'(m_e.pe));
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        rx         = 1'b1;
        baud_div   = 16'd0;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        rx_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_parity_err", 32'(parity_err), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        drive_bit(1'b1, 5);

        // Good frame, latency from the start edge.
        expect_byte(8'hA5, 1'b0, 1'b0);
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 16);
            begin
                lat = 0;
                while (!rx_valid && lat < 400) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                checks++;
                if (lat < 154 || lat > 156) begin
                    errors++;
                    $display("FAIL latency: got %0d expected 155+-1", lat);
                end
                chk("busy_after_stop", 32'(busy), 0);
                chk("overrun_a5", 32'(overrun), 0);
            end
        join

        // Glitch shorter than half a bit.
        drive_bit(1'b0, 4);
        rx = 1'b1;
        chk("false_start_busy_hi", 32'(busy), 1);
        drive_bit(1'b1, 20);
        chk("false_start_busy_lo", 32'(busy), 0);

        // Even parity: 0x07 needs parity bit 1.
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        expect_byte(8'h07, 1'b0, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 16);
        expect_byte(8'h07, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 16);
        parity_en = 1'b0;

        // Break: one 0x00 byte with frame error, then a clean frame.
        expect_byte(8'h00, 1'b1, 1'b0);
        expect_byte(8'h3C, 1'b0, 1'b0);
        drive_bit(1'b0, 20 * 16);
        drive_bit(1'b1, 16);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 16);

        // Overrun: second byte dropped while the first is held.
        rx_ready = 1'b0;
        chk("overrun_before", ov_cnt, 0);
        expect_byte(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 16);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 16);
        chk("overrun_pulses", ov_cnt, 1);
        chk("held_valid", 32'(rx_valid), 1);
        chk("held_data", 32'(rx_data), 32'h11);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("valid_drop", 32'(rx_valid), 0);

        // Reset in the middle of a data bit at baud_div=3.
        baud_div = 16'd3;
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 64);
        drive_bit(1'b1, 64);
        drive_bit(1'b0, 32);
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_valid", 32'(rx_valid), 0);
        chk("mid_rst_data", 32'(rx_data), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ferr", 32'(frame_err), 0);
        chk("mid_rst_perr", 32'(parity_err), 0);
        chk("mid_rst_ovr", 32'(overrun), 0);
        drive_bit(1'b1, 64);
        expect_byte(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 64);
        drive_bit(1'b1, 10);

        chk("bytes_missing", q.size(), 0);
        chk("overrun_total", ov_cnt, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
